// File: rtl/sram_arb_pkg.sv
// Purpose: shared types and constants for the inst/data SRAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_arb_pkg;

  // Width of the wait-state counter and the starvation streak counter.
  localparam int CNT_W = 4;

  // IDLE: nothing outstanding; WAIT: access in flight with cnt > 0;
  // RESP: outstanding access completes in this cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Which requester owns the outstanding access.
  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  // One requester's memory-side fields, muxed as a unit onto the SRAM.
  typedef struct packed {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Increment that sticks at the limit; the streak never exceeds it.
  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic [CNT_W-1:0] lim
  );
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Purpose: choose which requester wins the current issue slot.
// Latency: purely combinational, same-cycle grant.
// Backpressure: no grant while slot_en is low; the loser simply sees gnt low.
module sram_arb_pick
  import sram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             slot_en,
  input  logic             inst_req,
  input  logic             data_req,
  input  logic [CNT_W-1:0] streak,
  output logic             gnt_inst,
  output logic             gnt_data
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic starved;

  // Data normally wins a tie; inst wins once data has taken LIMIT grants in a row.
  always_comb begin
    starved  = (streak == LIMIT);
    gnt_data = slot_en & data_req & (~inst_req | ~starved);
    gnt_inst = slot_en & inst_req & (~data_req | starved);
  end

endmodule

// File: rtl/sram_arbiter.sv
// Purpose: share one single-ported synchronous SRAM between inst fetch and data access.
// Latency: grant is combinational; rvalid pulses 1+WAIT_CYCLES cycles after the grant.
// Backpressure: one access in flight; a requester not granted sees gnt low and must hold.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES  = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [3:0]  inst_wen,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] streak;
  owner_t           owner;

  logic     slot_en;
  logic     gnt_i;
  logic     gnt_d;
  logic     grant;
  mem_req_t inst_side;
  mem_req_t data_side;
  mem_req_t mem_sel;

  // An issue slot exists whenever nothing is mid-flight; reset kills it at once.
  assign slot_en = ~rst & (state != WAIT);
  assign grant   = gnt_i | gnt_d;

  assign inst_side = '{wen: inst_wen, addr: inst_addr, wdata: inst_wdata};
  assign data_side = '{wen: data_wen, addr: data_addr, wdata: data_wdata};

  sram_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .slot_en  (slot_en),
    .inst_req (inst_req),
    .data_req (data_req),
    .streak   (streak),
    .gnt_inst (gnt_i),
    .gnt_data (gnt_d)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a grant always wins, otherwise count down the wait states.
  always_comb begin
    state_nxt = state;
    if (grant) begin
      state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        WAIT:    state_nxt = (cnt == 1) ? RESP : WAIT;
        RESP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Owner and wait counter are captured at issue; cnt then runs down in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      owner <= OWN_INST;
    end else if (grant) begin
      cnt   <= WAIT_LD;
      owner <= gnt_d ? OWN_DATA : OWN_INST;
    end else if (state == WAIT) begin
      cnt   <= cnt - 1'b1;
    end
  end

  // Count data grants taken over a waiting inst request; any other grant clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (gnt_i || (grant && !inst_req)) begin
      streak <= '0;
    end else if (gnt_d) begin
      streak <= sat_inc(streak, LIMIT);
    end
  end

  // Outputs: winner's fields onto the SRAM, completion pulse routed to the owner.
  always_comb begin
    mem_sel = '0;
    if (gnt_d) begin
      mem_sel = data_side;
    end else if (gnt_i) begin
      mem_sel = inst_side;
    end
    mem_en      = grant;
    mem_wen     = mem_sel.wen;
    mem_addr    = mem_sel.addr;
    mem_wdata   = mem_sel.wdata;
    inst_gnt    = gnt_i;
    data_gnt    = gnt_d;
    inst_rvalid = (state == RESP) && (owner == OWN_INST);
    data_rvalid = (state == RESP) && (owner == OWN_DATA);
    inst_rdata  = inst_rvalid ? mem_rdata : '0;
    data_rdata  = data_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: three instances (WAIT_CYCLES 0, 3, 5), one active at a time.
// Inactive instances are held in reset; a scoreboard tracks expected completions.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic        inst_req   = 1'b0;
  logic        data_req   = 1'b0;
  logic [3:0]  inst_wen   = '0;
  logic [3:0]  data_wen   = '0;
  logic [31:0] inst_addr  = '0;
  logic [31:0] data_addr  = '0;
  logic [31:0] inst_wdata = '0;
  logic [31:0] data_wdata = '0;

  logic        rst_v         [3];
  logic        inst_gnt_v    [3];
  logic        data_gnt_v    [3];
  logic        inst_rvalid_v [3];
  logic        data_rvalid_v [3];
  logic [31:0] inst_rdata_v  [3];
  logic [31:0] data_rdata_v  [3];
  logic        mem_en_v      [3];
  logic [3:0]  mem_wen_v     [3];
  logic [31:0] mem_addr_v    [3];
  logic [31:0] mem_wdata_v   [3];
  logic [31:0] mem_rdata_v   [3];

  int sel         = 0;
  int cur_w       = 0;
  bit expect_resp = 1'b1;

  typedef struct {
    bit          own;
    logic [31:0] rdata;
    int          due;
  } exp_t;
  exp_t sbq[$];

  // SRAM contents seen by the bench: fixed per address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int W = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
    logic [31:0] pipe [0:5];

    // Synchronous SRAM model with 1+W cycles of read latency.
    always @(posedge clk) begin
      pipe[0] <= mem_en_v[g] ? mem_fn(mem_addr_v[g]) : 32'hCAFE_0000;
      for (int k = 1; k < 6; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata_v[g] = pipe[W];

    sram_arbiter #(
      .WAIT_CYCLES  (W),
      .STARVE_LIMIT (4)
    ) u_dut (
      .clk         (clk),
      .rst         (rst_v[g]),
      .inst_req    (inst_req),
      .inst_wen    (inst_wen),
      .inst_addr   (inst_addr),
      .inst_wdata  (inst_wdata),
      .inst_gnt    (inst_gnt_v[g]),
      .inst_rvalid (inst_rvalid_v[g]),
      .inst_rdata  (inst_rdata_v[g]),
      .data_req    (data_req),
      .data_wen    (data_wen),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_gnt    (data_gnt_v[g]),
      .data_rvalid (data_rvalid_v[g]),
      .data_rdata  (data_rdata_v[g]),
      .mem_en      (mem_en_v[g]),
      .mem_wen     (mem_wen_v[g]),
      .mem_addr    (mem_addr_v[g]),
      .mem_wdata   (mem_wdata_v[g]),
      .mem_rdata   (mem_rdata_v[g])
    );
  end

  // Monitor: every completion pulse must match the oldest expected response.
  always @(negedge clk) begin : mon
    exp_t e;
    if (inst_rvalid_v[sel] || data_rvalid_v[sel]) begin
      if (inst_rvalid_v[sel] && data_rvalid_v[sel]) begin
        chk("dual_rvalid", {31'd0, data_rvalid_v[sel]}, 32'd0);
      end else if (sbq.size() == 0) begin
        chk("unexpected_rvalid", {30'd0, inst_rvalid_v[sel], data_rvalid_v[sel]}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("rsp_owner", {31'd0, data_rvalid_v[sel]}, {31'd0, e.own});
        chk("rsp_cycle", cyc, e.due);
        if (e.own) begin
          chk("rsp_rdata", data_rdata_v[sel], e.rdata);
          chk("idle_rdata", inst_rdata_v[sel], 32'd0);
        end else begin
          chk("rsp_rdata", inst_rdata_v[sel], e.rdata);
          chk("idle_rdata", data_rdata_v[sel], 32'd0);
        end
      end
    end
  end

  // Drive one cycle of requests and check the expected grant and memory strobe.
  task automatic step(input logic ir, input logic dr, input logic [3:0] iw, input logic [3:0] dw,
                      input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                      input logic eig, input logic edg);
    @(posedge clk);
    #1;
    inst_req = ir;  data_req = dr;
    inst_wen = iw;  data_wen = dw;
    inst_addr = ia; data_addr = da;
    inst_wdata = wd; data_wdata = wd;
    @(negedge clk);
    chk("inst_gnt", {31'd0, inst_gnt_v[sel]}, {31'd0, eig});
    chk("data_gnt", {31'd0, data_gnt_v[sel]}, {31'd0, edg});
    chk("mem_en", {31'd0, mem_en_v[sel]}, {31'd0, eig | edg});
    if (edg) begin
      chk("mem_wen", {28'd0, mem_wen_v[sel]}, {28'd0, dw});
      chk("mem_addr", mem_addr_v[sel], da);
      chk("mem_wdata", mem_wdata_v[sel], wd);
      if (expect_resp) sbq.push_back('{1'b1, mem_fn(da), cyc + 1 + cur_w});
    end else if (eig) begin
      chk("mem_wen", {28'd0, mem_wen_v[sel]}, {28'd0, iw});
      chk("mem_addr", mem_addr_v[sel], ia);
      chk("mem_wdata", mem_wdata_v[sel], wd);
      if (expect_resp) sbq.push_back('{1'b0, mem_fn(ia), cyc + 1 + cur_w});
    end else begin
      chk("mem_wen_idle", {28'd0, mem_wen_v[sel]}, 32'd0);
      chk("mem_addr_idle", mem_addr_v[sel], 32'd0);
      chk("mem_wdata_idle", mem_wdata_v[sel], 32'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 4'h0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_inst_gnt"}, {31'd0, inst_gnt_v[sel]}, 32'd0);
    chk({tag, "_data_gnt"}, {31'd0, data_gnt_v[sel]}, 32'd0);
    chk({tag, "_inst_rvalid"}, {31'd0, inst_rvalid_v[sel]}, 32'd0);
    chk({tag, "_data_rvalid"}, {31'd0, data_rvalid_v[sel]}, 32'd0);
    chk({tag, "_mem_en"}, {31'd0, mem_en_v[sel]}, 32'd0);
    chk({tag, "_mem_wen"}, {28'd0, mem_wen_v[sel]}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr_v[sel], 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata_v[sel], 32'd0);
    chk({tag, "_inst_rdata"}, inst_rdata_v[sel], 32'd0);
    chk({tag, "_data_rdata"}, data_rdata_v[sel], 32'd0);
  endtask

  // Expected contention grant order with STARVE_LIMIT=4: D,D,D,D,I,D,D,D,D,I (1 = inst).
  logic [9:0] cont_inst = 10'b10000_10000;

  initial begin
    rst_v[0] = 1'b1; rst_v[1] = 1'b1; rst_v[2] = 1'b1;

    // ---- Instance 0: WAIT_CYCLES=0 ----
    sel = 0; cur_w = 0;
    // Requests present during reset must not be granted.
    inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h44; data_addr = 32'h88; data_wen = 4'hF;
    #2;
    chk_reset_outputs("rst0");
    chk("rst0_state", {30'd0, gen_dut[0].u_dut.state}, {30'd0, IDLE});
    inst_req = 1'b0; data_req = 1'b0; inst_addr = '0; data_addr = '0; data_wen = '0;
    @(posedge clk); #1 rst_v[0] = 1'b0;

    // Lone read: grant at T, DEADBEEF at T+1, mem_en low at T+1.
    step(1'b0, 1'b1, 4'h0, 4'h0, '0, 32'h1000, '0, 1'b0, 1'b1);
    idle(1);

    // Contention for 10 cycles.
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b1, 4'h0, 4'h0, 32'h100, 32'h200, '0, cont_inst[i], !cont_inst[i]);
    idle(2);

    // Write completion.
    step(1'b0, 1'b1, 4'h0, 4'b0011, '0, 32'h20, 32'h1234_5678, 1'b0, 1'b1);
    idle(2);

    // Overlap: data read at T, inst request at T+1 granted during data's RESP.
    step(1'b0, 1'b1, 4'h0, 4'h0, '0, 32'h300, '0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h400, '0, '0, 1'b1, 1'b0);
    idle(2);
    rst_v[0] = 1'b1;

    // ---- Instance 1: WAIT_CYCLES=3 ----
    sel = 1; cur_w = 3;
    #1;
    chk_reset_outputs("rst1");
    @(posedge clk); #1 rst_v[1] = 1'b0;
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h500, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 4'h0, 4'h0, 32'h600, 32'h700, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'h0, 4'h0, 32'h600, 32'h700, '0, 1'b0, 1'b1);
    idle(5);
    rst_v[1] = 1'b1;

    // ---- Instance 2: WAIT_CYCLES=5, reset mid-access ----
    sel = 2; cur_w = 5;
    #1;
    chk_reset_outputs("rst2");
    @(posedge clk); #1 rst_v[2] = 1'b0;
    expect_resp = 1'b0;
    step(1'b0, 1'b1, 4'h0, 4'h0, '0, 32'h800, '0, 1'b0, 1'b1);
    idle(1);
    @(posedge clk);
    #1 rst_v[2] = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    chk("midrst_state", {30'd0, gen_dut[2].u_dut.state}, {30'd0, IDLE});
    chk("midrst_cnt", {28'd0, gen_dut[2].u_dut.cnt}, 32'd0);
    chk("midrst_owner", {31'd0, gen_dut[2].u_dut.owner}, 32'd0);
    chk("midrst_streak", {28'd0, gen_dut[2].u_dut.streak}, 32'd0);
    #1 rst_v[2] = 1'b0;
    expect_resp = 1'b1;
    idle(8);
    step(1'b0, 1'b1, 4'h0, 4'h0, '0, 32'h900, '0, 1'b0, 1'b1);
    idle(7);

    @(negedge clk);
    chk("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
